pixel_stream_feeder: RTL and testbench
======================================

Name: pixel_stream_feeder

Overview:
- Hardware source for the edge-detection pipeline. Streams a stored greyscale frame out of a pixel RAM into the image-process slave stream, paced by the processor's line-buffer interrupt.
- Sits between the frame memory and the processor top's i_data / i_data_valid / o_intr interface, in place of a software or bench driver.
- Sends an initial fill of PRIME_LINES buffers. After that, sends one BUF_SIZE chunk per interrupt, then PAD_LINES zero chunks to flush the final rows.

Parameters:
- BUF_SIZE, 256, beats per chunk (one line buffer).
- PRIME_LINES, 4, chunks sent back-to-back after start, with no interrupt wait.
- PAD_LINES, 2, all-zero chunks sent after the image data, one per interrupt.
- TOTAL_PIXELS, 51529, image pixel count (227*227).
- ADDR_W, 16, pixel RAM address width; must satisfy 2^ADDR_W >= TOTAL_PIXELS.

Ports:
- axi_clk, in, 1, clock.
- axi_reset_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, one-cycle start pulse; ignored unless in IDLE.
- o_busy, out, 1, high from start until DONE.
- o_done, out, 1, one-cycle pulse at completion.
- o_mem_addr, out, ADDR_W, pixel RAM read address.
- o_mem_rd, out, 1, read enable; data returns one cycle later.
- i_mem_data, in, 8, RAM read data.
- o_data, out, 8, stream pixel.
- o_data_valid, out, 1, stream valid.
- i_data_ready, in, 1, stream ready from the processor.
- i_intr, in, 1, processor line-free interrupt (level, active high).
- o_intr_overrun, out, 1, sticky flag: interrupt arrived while one was already pending.
- o_stall_cnt, out, 32, backpressure cycle count (see Optional Feature).

Behaviour:
- Reset (asynchronous): state IDLE, and every output is 0 (o_data, o_data_valid, o_mem_rd, o_mem_addr, o_busy, o_done, o_intr_overrun, o_stall_cnt). Pixel index, chunk beat counter and pending flag are cleared. A reset mid-frame aborts the frame; no done pulse is issued.
- Beat transfer occurs on any cycle with o_data_valid & i_data_ready. Once o_data_valid is asserted, o_data holds until the transfer.
- Read path uses a 2-entry skid buffer. A read is issued only if a slot is guaranteed at the return cycle. Sustained throughput is 1 beat/cycle under continuous ready. Latency from the first read to the first o_data_valid is 2 cycles.
- Beats with pixel index >= TOTAL_PIXELS emit 0x00 and issue no RAM read. The pixel index increments per issued beat and never wraps. o_mem_addr equals the pixel index.
- Interrupt handling: a rising edge of i_intr (registered) sets the pending flag.
  - If the flag is already set, the edge is dropped and o_intr_overrun sets (cleared only by reset).
  - Pending is consumed on entry to SEND or PAD_SEND.
  - An edge arriving in the same cycle as consumption leaves pending set.
- FSM:
  - IDLE: on i_start, set o_busy, clear index, counters and pending, go to PRIME.
  - PRIME: issue PRIME_LINES*BUF_SIZE beats. When the last beat transfers, sent = PRIME_LINES*BUF_SIZE. Go to WAIT if sent < TOTAL_PIXELS, else PAD_WAIT with pad count 0.
  - WAIT: when pending is set, go to SEND.
  - SEND: issue exactly BUF_SIZE beats, with zero-fill past the image. After the last transfer, sent += BUF_SIZE. Go to WAIT if sent < TOTAL_PIXELS, else PAD_WAIT.
  - PAD_WAIT: if pad count == PAD_LINES, go to DONE; else, when pending is set, go to PAD_SEND.
  - PAD_SEND: issue BUF_SIZE beats of 0x00 with no reads, then increment pad count and go to PAD_WAIT.
  - DONE: pulse o_done, clear o_busy, go to IDLE.
- The chunk-end transition waits for the last beat's transfer, not just its issue. No beats are issued in WAIT or PAD_WAIT, so o_data_valid is low there once the skid buffer drains.

Optional Feature:
- Macro FEEDER_STALL_CNT_EN.
- Defined: o_stall_cnt increments (saturating at 0xFFFFFFFF) on each cycle with o_data_valid & !i_data_ready. It clears on i_start accepted in IDLE and on reset.
- Undefined: no counter logic; o_stall_cnt is tied to 0.

Test Plan:
All scenarios use BUF_SIZE=4, PRIME_LINES=4, PAD_LINES=2, TOTAL_PIXELS=18, with RAM[a]=a+1.
- Ready held 1; start, then one i_intr pulse per WAIT/PAD_WAIT -> 28 beats total:
  - first 16 beats are 1..16 on consecutive cycles (no interrupt needed);
  - after the 1st intr: 17, 18, 0, 0;
  - after the 2nd and 3rd intr: 0, 0, 0, 0 each;
  - one o_done pulse, o_busy low, 0 reads with address >= 18.
- Ready toggling 1-0 every cycle during PRIME -> same 16-value sequence, no duplicates or drops, o_data stable while stalled, o_stall_cnt=15 when the macro is defined and 0 when undefined.
- Intr pulsed during PRIME (before WAIT) -> pending is retained; SEND starts immediately on entry to WAIT; o_intr_overrun stays 0.
- Two intr edges during PRIME -> o_intr_overrun=1; only one chunk is sent before the next intr is needed.
- axi_reset_n low mid-SEND -> all outputs 0 immediately (asynchronous); no o_done; a new start replays from pixel 1.
- i_start pulsed while o_busy -> ignored; the beat sequence is unchanged.

Source files
------------

// File: rtl/pixel_stream_feeder.sv
// Streams a stored greyscale frame from pixel RAM to the image processor, paced by its line-free interrupt.
// Optional backpressure counter on o_stall_cnt is enabled by defining FEEDER_STALL_CNT_EN.
module pixel_stream_feeder #(
    parameter int BUF_SIZE     = 256,
    parameter int PRIME_LINES  = 4,
    parameter int PAD_LINES    = 2,
    parameter int TOTAL_PIXELS = 51529,
    parameter int ADDR_W       = 16
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_data,
    output logic [7:0]        o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    input  logic              i_intr,
    output logic              o_intr_overrun,
    output logic [31:0]       o_stall_cnt
);

    localparam int PRIME_BEATS = PRIME_LINES * BUF_SIZE;
    localparam int MAX_CHUNK   = (PRIME_BEATS > BUF_SIZE) ? PRIME_BEATS : BUF_SIZE;
    localparam int CNT_W       = $clog2(MAX_CHUNK + 1);
    localparam int PAD_W       = $clog2(PAD_LINES + 2);

    localparam logic [CNT_W-1:0]  PRIME_LEN  = CNT_W'(PRIME_BEATS);
    localparam logic [CNT_W-1:0]  BUF_LEN    = CNT_W'(BUF_SIZE);
    localparam logic [CNT_W-1:0]  PRIME_LAST = CNT_W'(PRIME_BEATS - 1);
    localparam logic [CNT_W-1:0]  BUF_LAST   = CNT_W'(BUF_SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);
    localparam logic [PAD_W-1:0]  PAD_ONE    = PAD_W'(1);
    localparam logic [PAD_W-1:0]  PAD_LAST   = PAD_W'(PAD_LINES);
    localparam logic [31:0]       TOTAL_W    = 32'(TOTAL_PIXELS);
    localparam logic [31:0]       PRIME_W    = 32'(PRIME_BEATS);
    localparam logic [31:0]       BUF_W      = 32'(BUF_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_WAIT,
        S_SEND,
        S_PAD_WAIT,
        S_PAD_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  xfer_q, xfer_d;
    logic [31:0]       sent_q, sent_d;
    logic [PAD_W-1:0]  pad_q, pad_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              intr_s1_q, intr_s2_q;
    logic              fly_q, fly_d;
    logic              fly_zero_q, fly_zero_d;
    logic [7:0]        buf0_q, buf0_d;
    logic [7:0]        buf1_q, buf1_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              active;
    logic              pop;
    logic              issue;
    logic              zero_beat;
    logic              last_xfer;
    logic              intr_edge;
    logic              consume;
    logic              start_acc;
    logic [2:0]        occ_next;
    logic [CNT_W-1:0]  chunk_len;
    logic [CNT_W-1:0]  chunk_last;
    logic [31:0]       sent_nxt;
    logic [7:0]        wr_data;

    // Issue control: a read goes out only if the skid buffer is certain to have a slot when it returns.
    always_comb begin
        active     = (state_q == S_PRIME) || (state_q == S_SEND) || (state_q == S_PAD_SEND);
        chunk_len  = (state_q == S_PRIME) ? PRIME_LEN : BUF_LEN;
        chunk_last = (state_q == S_PRIME) ? PRIME_LAST : BUF_LAST;
        pop        = (cnt_q != 2'd0) && i_data_ready;
        occ_next   = {1'b0, cnt_q} + {2'b00, fly_q} - {2'b00, pop};
        issue      = active && (beat_q < chunk_len) && (occ_next <= 3'd1);
        zero_beat  = (state_q == S_PAD_SEND) || (32'(idx_q) >= TOTAL_W);
        last_xfer  = active && pop && (xfer_q == chunk_last);
        intr_edge  = intr_s1_q && !intr_s2_q;
    end

    always_comb begin
        cnt_d      = cnt_q + {1'b0, fly_q} - {1'b0, pop};
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        wr_data    = fly_zero_q ? 8'h00 : i_mem_data;
        wr_ptr_d   = wr_ptr_q ^ fly_q;
        rd_ptr_d   = rd_ptr_q ^ pop;
        fly_d      = issue;
        fly_zero_d = issue && zero_beat;
        if (fly_q) begin
            if (wr_ptr_q) buf1_d = wr_data;
            else          buf0_d = wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        xfer_d    = xfer_q;
        sent_d    = sent_q;
        pad_d     = pad_q;
        consume   = 1'b0;
        start_acc = 1'b0;
        sent_nxt  = sent_q + BUF_W;
        if (issue) begin
            beat_d = beat_q + CNT_ONE;
            if (idx_q != {ADDR_W{1'b1}}) idx_d = idx_q + IDX_ONE;
        end
        if (pop) xfer_d = xfer_q + CNT_ONE;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_d   = S_PRIME;
                    idx_d     = '0;
                    beat_d    = '0;
                    xfer_d    = '0;
                    sent_d    = '0;
                    pad_d     = '0;
                end
            end
            S_PRIME: begin
                if (last_xfer) begin
                    sent_d  = PRIME_W;
                    state_d = (PRIME_W < TOTAL_W) ? S_WAIT : S_PAD_WAIT;
                end
            end
            S_WAIT: begin
                if (pend_q) begin
                    consume = 1'b1;
                    state_d = S_SEND;
                    beat_d  = '0;
                    xfer_d  = '0;
                end
            end
            S_SEND: begin
                if (last_xfer) begin
                    sent_d  = sent_nxt;
                    state_d = (sent_nxt < TOTAL_W) ? S_WAIT : S_PAD_WAIT;
                end
            end
            S_PAD_WAIT: begin
                if (pad_q == PAD_LAST) begin
                    state_d = S_DONE;
                end else if (pend_q) begin
                    consume = 1'b1;
                    state_d = S_PAD_SEND;
                    beat_d  = '0;
                    xfer_d  = '0;
                end
            end
            S_PAD_SEND: begin
                if (last_xfer) begin
                    pad_d   = pad_q + PAD_ONE;
                    state_d = S_PAD_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // An edge landing in the cycle pending is consumed re-arms it without counting as an overrun.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (start_acc) begin
            pend_d = 1'b0;
        end else begin
            if (consume) pend_d = 1'b0;
            if (intr_edge) begin
                if (pend_q && !consume) ovr_d = 1'b1;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            beat_q     <= '0;
            xfer_q     <= '0;
            sent_q     <= '0;
            pad_q      <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            intr_s1_q  <= 1'b0;
            intr_s2_q  <= 1'b0;
            fly_q      <= 1'b0;
            fly_zero_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            xfer_q     <= xfer_d;
            sent_q     <= sent_d;
            pad_q      <= pad_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            intr_s1_q  <= i_intr;
            intr_s2_q  <= intr_s1_q;
            fly_q      <= fly_d;
            fly_zero_q <= fly_zero_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done         = (state_q == S_DONE);
    assign o_mem_addr     = idx_q;
    assign o_mem_rd       = issue && !zero_beat;
    assign o_data         = rd_ptr_q ? buf1_q : buf0_q;
    assign o_data_valid   = (cnt_q != 2'd0);
    assign o_intr_overrun = ovr_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (o_data_valid && !i_data_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) stall_q <= '0;
        else              stall_q <= stall_d;
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Scoreboard bench for pixel_stream_feeder: a 4-beat chunk, 18-pixel frame with RAM[a] = a + 1.
module tb_pixel_stream_feeder;

    localparam int BUF_SIZE     = 4;
    localparam int PRIME_LINES  = 4;
    localparam int PAD_LINES    = 2;
    localparam int TOTAL_PIXELS = 18;
    localparam int ADDR_W       = 16;
    localparam int FRAME_BEATS  = 28;

    logic              axi_clk = 1'b0;
    logic              axi_reset_n = 1'b1;
    logic              i_start = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd;
    logic [7:0]        i_mem_data;
    logic [7:0]        o_data;
    logic              o_data_valid;
    logic              i_data_ready = 1'b1;
    logic              i_intr = 1'b0;
    logic              o_intr_overrun;
    logic [31:0]       o_stall_cnt;

    pixel_stream_feeder #(
        .BUF_SIZE    (BUF_SIZE),
        .PRIME_LINES (PRIME_LINES),
        .PAD_LINES   (PAD_LINES),
        .TOTAL_PIXELS(TOTAL_PIXELS),
        .ADDR_W      (ADDR_W)
    ) dut (
        .axi_clk       (axi_clk),
        .axi_reset_n   (axi_reset_n),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd      (o_mem_rd),
        .i_mem_data    (i_mem_data),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .i_data_ready  (i_data_ready),
        .i_intr        (i_intr),
        .o_intr_overrun(o_intr_overrun),
        .o_stall_cnt   (o_stall_cnt)
    );

    always #5 axi_clk = ~axi_clk;

    // Hand-computed beat stream: 16 prime pixels, 17/18 then zero fill, two all-zero pad chunks.
    logic [7:0] frame_tab [FRAME_BEATS] = '{
        8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,
        8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16,
        8'd17, 8'd18, 8'd0,  8'd0,
        8'd0,  8'd0,  8'd0,  8'd0,
        8'd0,  8'd0,  8'd0,  8'd0
    };

    logic [7:0] exp_q [$];
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int xfer_total  = 0;
    int done_total  = 0;
    int bad_rd      = 0;
    int last_cyc    = 0;
    int base        = 0;
    int base_done   = 0;
    int base_bad    = 0;
    bit chk_consec  = 1'b0;
    bit prev_stall  = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] ram_q = 8'd0;

    assign i_mem_data = ram_q;

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Pixel RAM model with one-cycle read latency.
    always @(posedge axi_clk) begin
        cyc <= cyc + 1;
        if (o_mem_rd) begin
            ram_q <= o_mem_addr[7:0] + 8'd1;
            if (o_mem_addr >= 16'(TOTAL_PIXELS)) bad_rd <= bad_rd + 1;
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stall hold.
    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", o_data_valid, 1);
                check("hold_data", o_data, prev_data);
            end
            if (o_data_valid && i_data_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_unexpected: got %0d, expected no beat (t=%0t)", o_data, $time);
                end else begin
                    check("beat", o_data, exp_q.pop_front());
                end
                if (chk_consec && (xfer_total - base) >= 1 && (xfer_total - base) <= 15)
                    check("consecutive", cyc - last_cyc, 1);
                xfer_total++;
                last_cyc = cyc;
            end
            prev_stall = o_data_valid && !i_data_ready;
            prev_data  = o_data;
            if (o_done) done_total++;
        end
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic begin_frame(input bit consec);
        base       = xfer_total;
        base_done  = done_total;
        base_bad   = bad_rd;
        chk_consec = consec;
        for (int i = 0; i < FRAME_BEATS; i++) exp_q.push_back(frame_tab[i]);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k;
        k = 0;
        while ((xfer_total - base) < n && k < 300) begin
            tick();
            k++;
        end
        check(tag, xfer_total - base, n);
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        tick();
        i_intr = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_total == base_done && k < 100) begin
            tick();
            k++;
        end
        tick();
        tick();
        check("done_pulses", done_total - base_done, 1);
        check("busy_after_done", o_busy, 0);
        check("bad_reads", bad_rd - base_bad, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic finish_frame();
        wait_beats(16, "prime_beats");
        pulse_intr();
        wait_beats(20, "send_beats");
        pulse_intr();
        wait_beats(24, "pad1_beats");
        pulse_intr();
        wait_beats(28, "pad2_beats");
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_valid"}, o_data_valid, 0);
        check({tag, "_rd"}, o_mem_rd, 0);
        check({tag, "_addr"}, o_mem_addr, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_overrun"}, o_intr_overrun, 0);
        check({tag, "_stall"}, o_stall_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int t16;
        #2;
        axi_reset_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) tick();
        axi_reset_n = 1'b1;
        tick();

        // Continuous ready, one interrupt per wait state.
        begin_frame(1'b1);
        finish_frame();
        check("overrun_t1", o_intr_overrun, 0);

        // Ready toggling during prime: transfers on odd cycles after start, stalls between them.
        begin_frame(1'b0);
        for (int k = 1; k <= 40; k++) begin
            i_data_ready = (k % 2 == 1);
            tick();
        end
        i_data_ready = 1'b1;
        finish_frame();
`ifdef FEEDER_STALL_CNT_EN
        check("stall_cnt", o_stall_cnt, 15);
`else
        check("stall_cnt", o_stall_cnt, 0);
`endif

        // Interrupt during prime is held and launches SEND straight away.
        begin_frame(1'b0);
        wait_beats(3, "early_intr_pre");
        pulse_intr();
        wait_beats(16, "early_prime");
        t16 = last_cyc;
        wait_beats(17, "early_send_start");
        check("early_send_gap_ok", (last_cyc - t16) <= 5, 1);
        wait_beats(20, "early_send");
        pulse_intr();
        wait_beats(24, "early_pad1");
        pulse_intr();
        wait_beats(28, "early_pad2");
        wait_done();
        check("overrun_t3", o_intr_overrun, 0);

        // Two edges during prime: overrun, and only one chunk rides on the pending flag.
        begin_frame(1'b0);
        wait_beats(2, "ovr_pre");
        pulse_intr();
        tick();
        pulse_intr();
        wait_beats(20, "ovr_send");
        repeat (20) tick();
        check("ovr_no_extra_chunk", xfer_total - base, 20);
        check("ovr_still_busy", o_busy, 1);
        check("overrun_set", o_intr_overrun, 1);
        pulse_intr();
        wait_beats(24, "ovr_pad1");
        pulse_intr();
        wait_beats(28, "ovr_pad2");
        wait_done();
        check("overrun_sticky", o_intr_overrun, 1);

        // Asynchronous reset in the middle of SEND.
        begin_frame(1'b0);
        wait_beats(16, "abort_prime");
        pulse_intr();
        wait_beats(17, "abort_send");
        #2;
        axi_reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (3) tick();
        check("abort_no_done", done_total - base_done, 0);
        axi_reset_n = 1'b1;
        tick();
        begin_frame(1'b1);
        finish_frame();

        // Start pulses while busy must not disturb the stream.
        begin_frame(1'b1);
        wait_beats(5, "busy_start_pre");
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_beats(16, "busy_start_prime");
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        pulse_intr();
        wait_beats(20, "busy_start_send");
        pulse_intr();
        wait_beats(24, "busy_start_pad1");
        pulse_intr();
        wait_beats(28, "busy_start_pad2");
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
